// File: rtl/writeback_unit_pkg.sv
// Shared types and sizing constants for the core's register-file writeback path.
package cpu_core_params;

    typedef logic [31:0] CpuData;
    typedef logic [4:0]  RegAddress;

    typedef struct packed {
        RegAddress address;
        CpuData    data;
    } WbRequest;

    localparam int WB_FIFO_DEPTH   = 2;
    localparam int WB_STARVE_LIMIT = 4;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Small synchronous FIFO buffering long-latency writeback requests.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module writeback_fifo
    import cpu_core_params::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  WbRequest push_data,
    input  logic     pop,
    output WbRequest head,
    output logic     full,
    output logic     empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    WbRequest       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [AW-1:0]  wr_index;
    logic [AW-1:0]  rd_index;

    assign wr_index = wr_ptr[AW-1:0];
    assign rd_index = rd_ptr[AW-1:0];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_index == rd_index);
    assign head  = mem[rd_index];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push && !full) begin
            mem[wr_index] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Merges pipeline and long-latency writebacks onto the register-file write port.
// Define WRITEBACK_BYPASS_EN to forward the committing write to decode queries.
module writeback_unit
    import cpu_core_params::*;
#(
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [4:0]  issue_address,
    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [4:0]  pipe_address,
    input  logic [31:0] pipe_data,
    input  logic        long_valid,
    output logic        long_ready,
    input  logic [4:0]  long_address,
    input  logic [31:0] long_data,
    input  logic [4:0]  query_address_1,
    input  logic [4:0]  query_address_2,
    output logic        query_busy_1,
    output logic        query_busy_2,
`ifdef WRITEBACK_BYPASS_EN
    output logic [31:0] bypass_data_1,
    output logic [31:0] bypass_data_2,
`endif
    output logic        write_enabled,
    output logic [4:0]  write_address,
    output logic [31:0] write_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic [SW-1:0] starve;

    WbRequest pipe_req;
    WbRequest long_req;
    WbRequest fifo_head;
    WbRequest sel;

    logic fifo_full;
    logic fifo_empty;
    logic issue_fire;
    logic pipe_fire;
    logic long_fire;
    logic drain;
    logic sel_valid;

    assign pipe_req = '{address: pipe_address, data: pipe_data};
    assign long_req = '{address: long_address, data: long_data};

    assign issue_ready = !reset && !busy[issue_address];
    assign long_ready  = !reset && !fifo_full;
    // The FIFO gets the slot once the pipe has used up its allowance.
    assign pipe_ready  = !reset && !((starve == LIMIT) && !fifo_empty);

    assign issue_fire = issue_valid && issue_ready;
    assign pipe_fire  = pipe_valid && pipe_ready;
    assign long_fire  = long_valid && long_ready;
    assign drain      = !reset && !fifo_empty && !pipe_fire;

    assign sel_valid = pipe_fire || drain;
    assign sel       = pipe_fire ? pipe_req : fifo_head;

    writeback_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (long_fire),
        .push_data(long_req),
        .pop      (drain),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        busy_next = busy;
        if (write_enabled) begin
            busy_next[write_address] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_address] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy          <= '0;
            starve        <= '0;
            write_enabled <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
        end else begin
            busy <= busy_next;
            if (fifo_empty || drain) begin
                starve <= '0;
            end else if (pipe_fire && (starve != LIMIT)) begin
                starve <= starve + SW'(1);
            end
            write_enabled <= sel_valid && (sel.address != '0);
            if (sel_valid) begin
                write_address <= sel.address;
                write_data    <= sel.data;
            end
        end
    end

`ifdef WRITEBACK_BYPASS_EN
    logic hit_1;
    logic hit_2;

    assign hit_1 = write_enabled && (write_address == query_address_1);
    assign hit_2 = write_enabled && (write_address == query_address_2);

    assign query_busy_1  = busy[query_address_1] && !hit_1;
    assign query_busy_2  = busy[query_address_2] && !hit_2;
    assign bypass_data_1 = hit_1 ? write_data : '0;
    assign bypass_data_2 = hit_2 ? write_data : '0;
`else
    assign query_busy_1 = busy[query_address_1];
    assign query_busy_2 = busy[query_address_2];
`endif

endmodule
